// File: rtl/serial_pkg.sv
// Shared constants and types for the serial echo path.
// The receiver, transmitter and line buffer all import this package.
package serial_pkg;

  // ASCII control characters that matter to line framing.
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // Link defaults shared by receiver and transmitter.
  localparam int DEFAULT_NUM_BITS = 8;
  localparam int DEFAULT_BAUD     = 115_200;

  // Line-buffer commit bookkeeping state; observable for debug only.
  typedef enum logic {
    ST_COLLECT = 1'b0,  // a line is open, or the buffer is idle
    ST_FLUSH   = 1'b1   // committed bytes waiting, no open line
  } line_state_e;

endpackage : serial_pkg

// File: rtl/serial_line_buffer_if.sv
// Byte-stream bundle between the receiver side, the line buffer and the
// transmitter side. The master drives bytes in and takes bytes out; the
// slave is the buffer itself.
interface serial_line_buffer_if #(
  parameter int NUM_BITS = 8,
  parameter int DEPTH    = 64
) ();

  // Upstream: one pulse per received byte.
  logic [NUM_BITS-1:0]     in_data;
  logic                    in_valid;

  // Downstream: first-word-fall-through byte stream with ready.
  logic [NUM_BITS-1:0]     out_data;
  logic                    out_valid;
  logic                    out_ready;

  // Status and control.
  logic [$clog2(DEPTH):0]  fill;
  logic                    overflow;
  logic                    clr_overflow;

  modport master (
    output in_data, in_valid, out_ready, clr_overflow,
    input  out_data, out_valid, fill, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready, clr_overflow,
    output out_data, out_valid, fill, overflow
  );

endinterface : serial_line_buffer_if

// File: rtl/serial_line_mem.sv
// Line buffer storage: DEPTH x NUM_BITS simple dual-port RAM with a
// synchronous write port and an asynchronous read port, so the byte at the
// read pointer is visible in the same cycle (first-word-fall-through).
module serial_line_mem #(
  parameter int NUM_BITS = 8,
  parameter int DEPTH    = 64,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [NUM_BITS-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [NUM_BITS-1:0] rd_data
);

  logic [NUM_BITS-1:0] mem [DEPTH];

  // Store one byte per accepted write.
  // NOTE: the array has no reset; the pointers and counters define which
  // entries hold data, so clearing the contents would only cost logic.
  // NOTE: sequential state uses non-blocking assignment so every register
  // in the design samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : serial_line_mem

// File: rtl/serial_line_buffer.sv
// Line buffer for the UART echo path. Bytes from the receiver are stored
// in a circular buffer and only released downstream once their line is
// complete: a terminator byte arrived, or the open line hit MAX_LINE bytes.
// Bytes arriving while the buffer is full are dropped and flagged in a
// sticky overflow bit.
//
// Bookkeeping: fill = pend + open, where pend counts committed unread bytes
// and open counts bytes of the line still being collected.
module serial_line_buffer
  import serial_pkg::*;
#(
  parameter int                    NUM_BITS   = DEFAULT_NUM_BITS,
  parameter int                    DEPTH      = 64,
  parameter int                    MAX_LINE   = DEPTH,
  parameter logic [NUM_BITS-1:0]   TERMINATOR = NUM_BITS'(ASCII_LF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_line_buffer_if.slave   bus,
  output line_state_e           state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] LINE_LIMIT = CW'(MAX_LINE);
  localparam logic [CW-1:0] ONE        = CW'(1);

  // Pointers wrap modulo DEPTH (a power of two) by natural overflow.
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Occupancy counters; none of these ever wrap.
  logic [CW-1:0] fill;
  logic [CW-1:0] pend;
  logic [CW-1:0] open;

  logic          out_valid;
  logic          overflow;

  // Per-cycle decisions.
  logic          full;
  logic          wr_en;
  logic          drop;
  logic          rd_en;
  logic          commit;
  logic [CW-1:0] open_inc;

  // Next-state values of the counters.
  logic [CW-1:0] fill_next;
  logic [CW-1:0] pend_next;
  logic [CW-1:0] open_next;

  // Full is judged on the registered fill, so a read in the same cycle
  // does not make room for an incoming byte.
  assign full     = (fill == FULL_LEVEL);
  assign wr_en    = bus.in_valid && !full;
  assign drop     = bus.in_valid && full;
  assign rd_en    = out_valid && bus.out_ready;
  assign open_inc = open + ONE;

  // A line closes on the terminator itself or when it reaches MAX_LINE.
  assign commit   = wr_en && ((bus.in_data == TERMINATOR) || (open_inc == LINE_LIMIT));

  // Counter arithmetic for simultaneous write, read and commit.
  // NOTE: every output of this block gets a default first, so no path
  // through the branches can leave a value held and infer a latch.
  always_comb begin
    fill_next = fill;
    pend_next = pend;
    open_next = open;

    if (wr_en) begin
      fill_next = fill_next + ONE;
    end

    if (rd_en) begin
      fill_next = fill_next - ONE;
      pend_next = pend_next - ONE;
    end

    if (commit) begin
      pend_next = pend_next + open_inc;
      open_next = '0;
    end else if (wr_en) begin
      open_next = open_inc;
    end
  end

  // Pointer and counter registers; a reset discards every buffered byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      pend   <= '0;
      open   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fill <= fill_next;
      pend <= pend_next;
      open <= open_next;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (bus.clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Control FSM with registered outputs. out_valid follows pend alone;
  // the state only records whether a line is open, for debug visibility.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (pend_next != '0);
      case (state)
        ST_COLLECT: begin
          if ((pend_next != '0) && (open_next == '0)) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if ((open_next != '0) || (pend_next == '0)) begin
            state <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

  serial_line_mem #(
    .NUM_BITS (NUM_BITS),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr),
    .rd_data (bus.out_data)
  );

  assign bus.out_valid = out_valid;
  assign bus.fill      = fill;
  assign bus.overflow  = overflow;

endmodule : serial_line_buffer

// File: tb/tb_serial_line_buffer.sv
// Bench for serial_line_buffer with a small buffer (DEPTH=8, MAX_LINE=4)
// so that forced commits, full/drop and pointer wrap are all reached quickly.
// Accepted bytes are queued when driven; a monitor pops and compares each
// byte the buffer hands out.
module tb_serial_line_buffer;
  import serial_pkg::*;

  localparam int NB       = 8;
  localparam int DEPTH    = 8;
  localparam int MAX_LINE = 4;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam logic [7:0] LF = 8'h0A;

  logic        clk = 1'b0;
  logic        rst_n;
  line_state_e state;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  serial_line_buffer_if #(.NUM_BITS(NB), .DEPTH(DEPTH)) bus ();

  serial_line_buffer #(
    .NUM_BITS   (NB),
    .DEPTH      (DEPTH),
    .MAX_LINE   (MAX_LINE),
    .TERMINATOR (LF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  // Output monitor: every handshaken byte must be the oldest accepted byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL out_data_unexpected: got %h with no byte expected", bus.out_data);
      end else begin
        logic [7:0] exp_b;
        exp_b = sb_q.pop_front();
        if (bus.out_data !== exp_b) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", bus.out_data, exp_b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for one cycle; queue it if the buffer should keep it.
  task automatic send_byte(input logic [7:0] b, input bit accept);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    if (accept) sb_q.push_back(b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Let the consumer run until the scoreboard empties or the budget ends.
  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.fill !== CW'(0)) begin errors++; $display("FAIL reset_fill: got %0d expected 0", bus.fill); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    tick();
  endtask

  // 'H','i',LF one byte every 10 cycles; nothing leaves until LF is stored.
  task automatic test_line_release();
    logic [7:0] msg [3];
    int bad;
    logic [CW-1:0] f;
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = LF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_byte(msg[i], 1'b1);
      bad = 0;
      f = '0;
      repeat (9) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b0) bad++;
        f = bus.fill;
        tick();
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL line_early_valid: got %0d valid cycles expected 0", bad); end
      checks++;
      if (f !== CW'(i + 1)) begin errors++; $display("FAIL line_fill: got %0d expected %0d", f, i + 1); end
    end
    send_byte(msg[2], 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic exp_v;
      @(negedge clk);
      exp_v = (i < 3);
      checks++;
      if (bus.out_valid !== exp_v) begin errors++; $display("FAIL line_release_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_v); end
    end
    checks++;
    if (bus.fill !== CW'(0)) begin errors++; $display("FAIL line_release_fill: got %0d expected 0", bus.fill); end
    tick();
  endtask

  // An unterminated short line stays put, even with out_ready held high.
  task automatic test_open_line();
    int bad;
    bus.out_ready = 1'b1;
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h63, 1'b1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
      tick();
    end
    @(negedge clk);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL open_line_valid: got %0d valid cycles expected 0", bad); end
    checks++;
    if (bus.fill !== CW'(3)) begin errors++; $display("FAIL open_line_fill: got %0d expected 3", bus.fill); end
    checks++;
    if (state !== ST_COLLECT) begin errors++; $display("FAIL open_line_state: got %0d expected %0d", state, ST_COLLECT); end
    tick();
    send_byte(LF, 1'b1);
    wait_drain(20);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL open_line_drain: got %0d bytes left expected 0", sb_q.size()); end
    checks++;
    if (bus.fill !== CW'(0)) begin errors++; $display("FAIL open_line_drain_fill: got %0d expected 0", bus.fill); end
    tick();
  endtask

  // Six bytes without LF: the first MAX_LINE are forced out, two stay open.
  task automatic test_max_line();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 1'b1);
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (bus.fill !== CW'(2)) begin errors++; $display("FAIL max_line_fill: got %0d expected 2", bus.fill); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL max_line_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (sb_q.size() != 2) begin errors++; $display("FAIL max_line_released: got %0d bytes held expected 2", sb_q.size()); end
    tick();
    send_byte(LF, 1'b1);
    wait_drain(20);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL max_line_drain: got %0d bytes left expected 0", sb_q.size()); end
    tick();
  endtask

  // Fill to DEPTH with the consumer stalled, then drop, clear and set-wins.
  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'h41 + 8'(i), 1'b1);
    send_byte(LF, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.fill !== CW'(8)) begin errors++; $display("FAIL full_fill: got %0d expected 8", bus.fill); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_early: got %b expected 0", bus.overflow); end
    checks++;
    if (state !== ST_FLUSH) begin errors++; $display("FAIL full_state: got %0d expected %0d", state, ST_FLUSH); end
    tick();
    send_byte(8'h58, 1'b0);
    send_byte(8'h59, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.fill !== CW'(8)) begin errors++; $display("FAIL drop_fill: got %0d expected 8", bus.fill); end
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b expected 1", bus.overflow); end
    tick();
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", bus.overflow); end
    tick();
    // Write, read and clear together while full: byte dropped, flag set.
    bus.in_data      = 8'h55;
    bus.in_valid     = 1'b1;
    bus.clr_overflow = 1'b1;
    bus.out_ready    = 1'b1;
    tick();
    bus.in_valid     = 1'b0;
    bus.clr_overflow = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL set_wins_overflow: got %b expected 1", bus.overflow); end
    checks++;
    if (bus.fill !== CW'(7)) begin errors++; $display("FAIL full_read_fill: got %0d expected 7", bus.fill); end
    tick();
    wait_drain(30);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL overflow_drain: got %0d bytes left expected 0", sb_q.size()); end
    checks++;
    if (bus.fill !== CW'(0)) begin errors++; $display("FAIL overflow_drain_fill: got %0d expected 0", bus.fill); end
    tick();
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
  endtask

  // Continuous 3-byte lines with reads overlapping writes across many wraps.
  task automatic test_back_to_back();
    int exp_fill;
    logic [7:0] b;
    bus.out_ready = 1'b1;
    exp_fill = -1;
    for (int i = 0; i < 30; i++) begin
      b = (i % 3 == 2) ? LF : 8'($urandom_range(8'h20, 8'h7E));
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      sb_q.push_back(b);
      @(negedge clk);
      if (exp_fill >= 0) begin
        checks++;
        if (int'(bus.fill) != exp_fill) begin errors++; $display("FAIL b2b_fill[%0d]: got %0d expected %0d", i, bus.fill, exp_fill); end
      end
      exp_fill = int'(bus.fill) + 1 - ((bus.out_valid === 1'b1) ? 1 : 0);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (int'(bus.fill) != exp_fill) begin errors++; $display("FAIL b2b_fill_last: got %0d expected %0d", bus.fill, exp_fill); end
    tick();
    wait_drain(30);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d bytes left expected 0", sb_q.size()); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", bus.overflow); end
    tick();
  endtask

  // One-cycle reset with pend=5, open=2 and overflow set; next line intact.
  task automatic test_reset_mid_line();
    bus.out_ready = 1'b0;
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(LF,    1'b1);
    send_byte(8'h63, 1'b1);
    send_byte(8'h64, 1'b1);
    send_byte(LF,    1'b1);
    send_byte(8'h65, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h67, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL pre_reset_overflow: got %b expected 1", bus.overflow); end
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fill !== CW'(7)) begin errors++; $display("FAIL pre_reset_fill: got %0d expected 7", bus.fill); end
    tick();
    rst_n = 1'b0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.fill !== CW'(0)) begin errors++; $display("FAIL mid_reset_fill: got %0d expected 0", bus.fill); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_overflow: got %b expected 0", bus.overflow); end
    tick();
    bus.out_ready = 1'b1;
    send_byte(8'h6F, 1'b1);
    send_byte(8'h6B, 1'b1);
    send_byte(LF,    1'b1);
    wait_drain(20);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL post_reset_echo: got %0d bytes left expected 0", sb_q.size()); end
    checks++;
    if (bus.fill !== CW'(0)) begin errors++; $display("FAIL post_reset_fill: got %0d expected 0", bus.fill); end
    tick();
  endtask

  initial begin
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    rst_n            = 1'b0;
    test_reset();
    test_line_release();
    test_open_line();
    test_max_line();
    test_overflow();
    test_back_to_back();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_line_buffer
